// File: rtl/aes_csr_bank_pkg.sv
// Shared register map offsets, CTRL/STATUS bit positions and the cipher mode enum
// for the AES CSR bank.
package aes_csr_pkg;

    localparam logic [7:0] CTRL_OFF       = 8'h00;
    localparam logic [7:0] MODE_OFF       = 8'h04;
    localparam logic [7:0] STATUS_OFF     = 8'h08;
    localparam logic [7:0] INTCLR_OFF     = 8'h0C;
    localparam logic [7:0] KEY_BASE_DFLT  = 8'h10;
    localparam logic [7:0] DIN_BASE_DFLT  = 8'h40;
    localparam logic [7:0] IV_BASE_DFLT   = 8'h60;
    localparam logic [7:0] DOUT_BASE_DFLT = 8'h80;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_DECRYPT = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    typedef enum logic [1:0] {
        MODE_ECB  = 2'd0,
        MODE_CBC  = 2'd1,
        MODE_CTR  = 2'd2,
        MODE_RSVD = 2'd3
    } aes_mode_e;

endpackage

// File: rtl/aes_csr_bank_if.sv
// Simple write/read strobe bus between the AXI-lite slave adapter and the CSR bank.
interface aes_csr_bank_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        output rd_data, rd_valid
    );
endinterface

// File: rtl/aes_csr_bank_word.sv
// 32-bit CSR word with per-byte write strobes, used for the KEY, IV and DIN arrays.
module aes_csr_word (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_en,
    input  logic [3:0]  i_strb,
    input  logic [31:0] i_data,
    output logic [31:0] o_q
);
    logic [31:0] r_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_q <= '0;
        end else if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_strb[i]) r_q[8*i +: 8] <= i_data[8*i +: 8];
            end
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/aes_csr_bank.sv
// CSR bank for the AES core: decode, START pulse, busy lock, sticky DONE/ERR with W1C,
// result snapshot on core_done and a registered read mux.
module aes_csr_bank
    import aes_csr_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         KEY_WORDS = 8,
    parameter int         BLK_WORDS = 4,
    parameter logic [7:0] KEY_BASE  = KEY_BASE_DFLT,
    parameter logic [7:0] DIN_BASE  = DIN_BASE_DFLT,
    parameter logic [7:0] IV_BASE   = IV_BASE_DFLT,
    parameter logic [7:0] DOUT_BASE = DOUT_BASE_DFLT
) (
    input  logic                     clk,
    input  logic                     resetn,
    aes_csr_bank_if.slave            bus,
    input  logic                     i_core_busy,
    input  logic                     i_core_done,
    input  logic [32*BLK_WORDS-1:0]  i_core_dout,
    output logic                     o_start,
    output logic                     o_decrypt,
    output logic [1:0]               o_mode,
    output logic [32*KEY_WORDS-1:0]  o_key,
    output logic [32*BLK_WORDS-1:0]  o_iv,
    output logic [32*BLK_WORDS-1:0]  o_din,
    output logic                     o_irq
);
    logic                    r_start, r_decrypt, r_irq_en, r_done, r_err, r_rd_valid;
    aes_mode_e               r_mode;
    logic [32*BLK_WORDS-1:0] r_dout_q;
    logic [31:0]             r_rd_data;

    logic [ADDR_W-1:0]       w_waddr, w_raddr;
    logic                    w_busy, w_ctrl_hit, w_mode_hit, w_clr_hit, w_data_hit;
    logic                    w_start_req, w_start_fire, w_err_set, w_clr_wr, w_clr_done, w_clr_err;
    logic [KEY_WORDS-1:0]    w_key_hit;
    logic [BLK_WORDS-1:0]    w_din_hit, w_iv_hit;
    logic [31:0]             w_key_q [KEY_WORDS];
    logic [31:0]             w_din_q [BLK_WORDS];
    logic [31:0]             w_iv_q  [BLK_WORDS];
    logic [31:0]             w_rd_mux;
    logic                    w_unused_addr;

    assign w_waddr = {bus.wr_addr[ADDR_W-1:2], 2'b00};
    assign w_raddr = {bus.rd_addr[ADDR_W-1:2], 2'b00};
    assign w_unused_addr = ^{bus.wr_addr[31:ADDR_W], bus.wr_addr[1:0],
                             bus.rd_addr[31:ADDR_W], bus.rd_addr[1:0]};

    // A START accepted last cycle counts as busy so a second START cannot sneak in.
    assign w_busy     = i_core_busy | r_start;
    assign w_ctrl_hit = (w_waddr == ADDR_W'(CTRL_OFF));
    assign w_mode_hit = (w_waddr == ADDR_W'(MODE_OFF));
    assign w_clr_hit  = (w_waddr == ADDR_W'(INTCLR_OFF));
    assign w_data_hit = w_mode_hit | (|w_key_hit) | (|w_din_hit) | (|w_iv_hit);

    assign w_start_req  = bus.wr_en && w_ctrl_hit && bus.wr_strb[0] && bus.wr_data[CTRL_START];
    assign w_start_fire = w_start_req && !w_busy;
    assign w_err_set    = (w_start_req && i_core_busy) || (bus.wr_en && w_data_hit && w_busy);
    assign w_clr_wr     = bus.wr_en && w_clr_hit && bus.wr_strb[0];
    assign w_clr_done   = w_clr_wr && bus.wr_data[ST_DONE];
    assign w_clr_err    = w_clr_wr && bus.wr_data[ST_ERR];

    for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_key
        assign w_key_hit[gi] = (w_waddr == ADDR_W'(int'(KEY_BASE) + 4*gi));
        aes_csr_word u_word (
            .clk(clk), .resetn(resetn),
            .i_en(bus.wr_en && w_key_hit[gi] && !w_busy),
            .i_strb(bus.wr_strb), .i_data(bus.wr_data), .o_q(w_key_q[gi])
        );
        assign o_key[32*gi +: 32] = w_key_q[gi];
    end

    for (genvar gi = 0; gi < BLK_WORDS; gi++) begin : g_blk
        assign w_din_hit[gi] = (w_waddr == ADDR_W'(int'(DIN_BASE) + 4*gi));
        assign w_iv_hit[gi]  = (w_waddr == ADDR_W'(int'(IV_BASE) + 4*gi));
        aes_csr_word u_din (
            .clk(clk), .resetn(resetn),
            .i_en(bus.wr_en && w_din_hit[gi] && !w_busy),
            .i_strb(bus.wr_strb), .i_data(bus.wr_data), .o_q(w_din_q[gi])
        );
        aes_csr_word u_iv (
            .clk(clk), .resetn(resetn),
            .i_en(bus.wr_en && w_iv_hit[gi] && !w_busy),
            .i_strb(bus.wr_strb), .i_data(bus.wr_data), .o_q(w_iv_q[gi])
        );
        assign o_din[32*gi +: 32] = w_din_q[gi];
        assign o_iv[32*gi +: 32]  = w_iv_q[gi];
    end

    always_comb begin
        w_rd_mux = '0;
        if (w_raddr == ADDR_W'(CTRL_OFF))   w_rd_mux = {29'd0, r_decrypt, r_irq_en, 1'b0};
        if (w_raddr == ADDR_W'(MODE_OFF))   w_rd_mux = {30'd0, r_mode};
        if (w_raddr == ADDR_W'(STATUS_OFF)) w_rd_mux = {29'd0, r_err, r_done, w_busy};
        for (int i = 0; i < KEY_WORDS; i++) begin
            if (w_raddr == ADDR_W'(int'(KEY_BASE) + 4*i)) w_rd_mux = w_key_q[i];
        end
        for (int i = 0; i < BLK_WORDS; i++) begin
            if (w_raddr == ADDR_W'(int'(DIN_BASE) + 4*i))  w_rd_mux = w_din_q[i];
            if (w_raddr == ADDR_W'(int'(IV_BASE) + 4*i))   w_rd_mux = w_iv_q[i];
            if (w_raddr == ADDR_W'(int'(DOUT_BASE) + 4*i)) w_rd_mux = r_dout_q[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_start    <= 1'b0;
            r_decrypt  <= 1'b0;
            r_irq_en   <= 1'b0;
            r_mode     <= MODE_ECB;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_dout_q   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_start <= w_start_fire;
            if (bus.wr_en && w_ctrl_hit && bus.wr_strb[0]) begin
                r_decrypt <= bus.wr_data[CTRL_DECRYPT];
                r_irq_en  <= bus.wr_data[CTRL_IRQ_EN];
            end
            if (bus.wr_en && w_mode_hit && bus.wr_strb[0] && !w_busy)
                r_mode <= aes_mode_e'(bus.wr_data[1:0]);
            // A completion in the same cycle as a clear or a new START keeps DONE set.
            if (i_core_done) begin
                r_done   <= 1'b1;
                r_dout_q <= i_core_dout;
            end else if (w_clr_done || w_start_fire) begin
                r_done <= 1'b0;
            end
            if (w_err_set)      r_err <= 1'b1;
            else if (w_clr_err) r_err <= 1'b0;
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) r_rd_data <= w_rd_mux;
        end
    end

    assign o_start      = r_start;
    assign o_decrypt    = r_decrypt;
    assign o_mode       = r_mode;
    assign o_irq        = r_done & r_irq_en;
    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_aes_csr_bank.sv
// Randomised and directed bench for aes_csr_bank against a register-map level model.
module tb_aes_csr_bank;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         core_busy = 1'b0;
    logic         core_done = 1'b0;
    logic [127:0] core_dout = '0;
    logic         o_start, o_decrypt, o_irq;
    logic [1:0]   o_mode;
    logic [255:0] o_key;
    logic [127:0] o_iv, o_din;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    aes_csr_bank_if bus ();

    aes_csr_bank dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .i_core_busy(core_busy), .i_core_done(core_done), .i_core_dout(core_dout),
        .o_start(o_start), .o_decrypt(o_decrypt), .o_mode(o_mode),
        .o_key(o_key), .o_iv(o_iv), .o_din(o_din), .o_irq(o_irq)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Register-map model: plain arrays updated from the architectural rules each edge.
    logic [31:0] m_key [8];
    logic [31:0] m_din [4];
    logic [31:0] m_iv  [4];
    logic [31:0] m_dout[4];
    logic [1:0]  m_mode = '0;
    logic        m_dec = 0, m_ien = 0, m_done = 0, m_err = 0, m_start = 0, m_rd_valid = 0;
    logic [31:0] m_rd_data = '0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] addr);
        logic [7:0] a = addr & 8'hFC;
        if (a == 8'h00) return {29'd0, m_dec, m_ien, 1'b0};
        if (a == 8'h04) return {30'd0, m_mode};
        if (a == 8'h08) return {29'd0, m_err, m_done, core_busy | m_start};
        if (a >= 8'h10 && a < 8'h30) return m_key[(a - 8'h10) >> 2];
        if (a >= 8'h40 && a < 8'h50) return m_din[(a - 8'h40) >> 2];
        if (a >= 8'h60 && a < 8'h70) return m_iv[(a - 8'h60) >> 2];
        if (a >= 8'h80 && a < 8'h90) return m_dout[(a - 8'h80) >> 2];
        return 32'd0;
    endfunction

    always @(posedge clk) begin : model
        logic [7:0]   wa;
        logic         mbusy, nstart, eset, cdone, cerr;
        logic [255:0] ek;
        logic [127:0] ed, ei;
        if (!resetn) begin
            for (int i = 0; i < 8; i++) m_key[i] = '0;
            for (int i = 0; i < 4; i++) begin
                m_din[i] = '0; m_iv[i] = '0; m_dout[i] = '0;
            end
            m_mode = '0; m_dec = 0; m_ien = 0; m_done = 0; m_err = 0;
            m_start = 0; m_rd_valid = 0; m_rd_data = '0;
        end else begin
            mbusy = core_busy | m_start;
            nstart = 0; eset = 0; cdone = 0; cerr = 0;
            if (bus.rd_en) m_rd_data = model_read(bus.rd_addr[7:0]);
            m_rd_valid = bus.rd_en;
            wa = bus.wr_addr[7:0] & 8'hFC;
            if (bus.wr_en) begin
                if (wa == 8'h00 && bus.wr_strb[0]) begin
                    m_dec = bus.wr_data[2];
                    m_ien = bus.wr_data[1];
                    if (bus.wr_data[0]) begin
                        if (core_busy) eset = 1;
                        else if (!m_start) nstart = 1;
                    end
                end else if (wa == 8'h0C && bus.wr_strb[0]) begin
                    cdone = bus.wr_data[1];
                    cerr  = bus.wr_data[2];
                end else if (wa == 8'h04 || (wa >= 8'h10 && wa < 8'h30) ||
                             (wa >= 8'h40 && wa < 8'h50) || (wa >= 8'h60 && wa < 8'h70)) begin
                    if (mbusy) eset = 1;
                    else if (wa == 8'h04) begin
                        if (bus.wr_strb[0]) m_mode = bus.wr_data[1:0];
                    end else if (wa < 8'h30) begin
                        m_key[(wa - 8'h10) >> 2] = merge(m_key[(wa - 8'h10) >> 2], bus.wr_data, bus.wr_strb);
                    end else if (wa < 8'h50) begin
                        m_din[(wa - 8'h40) >> 2] = merge(m_din[(wa - 8'h40) >> 2], bus.wr_data, bus.wr_strb);
                    end else begin
                        m_iv[(wa - 8'h60) >> 2] = merge(m_iv[(wa - 8'h60) >> 2], bus.wr_data, bus.wr_strb);
                    end
                end
            end
            if (core_done) begin
                m_done = 1;
                for (int i = 0; i < 4; i++) m_dout[i] = core_dout[32*i +: 32];
            end else if (cdone || nstart) begin
                m_done = 0;
            end
            if (eset) m_err = 1;
            else if (cerr) m_err = 0;
            m_start = nstart;
        end
        #1;
        for (int i = 0; i < 8; i++) ek[32*i +: 32] = m_key[i];
        for (int i = 0; i < 4; i++) begin
            ed[32*i +: 32] = m_din[i];
            ei[32*i +: 32] = m_iv[i];
        end
        check("start",    256'(o_start),      256'(m_start));
        check("irq",      256'(o_irq),        256'(m_done & m_ien));
        check("decrypt",  256'(o_decrypt),    256'(m_dec));
        check("mode",     256'(o_mode),       256'(m_mode));
        check("key",      o_key,              ek);
        check("din",      256'(o_din),        256'(ed));
        check("iv",       256'(o_iv),         256'(ei));
        check("rd_valid", 256'(bus.rd_valid), 256'(m_rd_valid));
        check("rd_data",  256'(bus.rd_data),  256'(m_rd_data));
    end

    task automatic wr_beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.wr_en = 1; bus.wr_addr = a; bus.wr_data = d; bus.wr_strb = s;
        $display("[TB] wr %08h <= %08h strb %b", a, d, s);
        @(negedge clk);
        bus.wr_en = 0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.rd_en = 1; bus.rd_addr = a;
        @(negedge clk);
        bus.rd_en = 0;
        d = bus.rd_data;
        check("rd_valid_lat", 256'(bus.rd_valid), 256'(1'b1));
        $display("[TB] rd %08h -> %08h", a, d);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] ra;
        bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
        bus.rd_en = 0; bus.rd_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {o_key[127:0], o_din[63:0], o_iv[59:0], o_start, o_irq, o_mode},
              256'd0);
        resetn = 1;

        for (int a = 0; a <= 'h8C; a += 4) begin
            rd(32'(a), d);
            check($sformatf("t1_rd_%02h", a), 256'(d), 256'd0);
        end

        wr_beat(32'h2C, 32'hDEADBEEF, 4'b0011);
        rd(32'h2C, d);
        check("t2_key7_rd", 256'(d), 256'(32'h0000BEEF));
        check("t2_key7_port", 256'(o_key[255:224]), 256'(32'h0000BEEF));

        wr_beat(32'h00, 32'h3, 4'hF);
        check("t3_start_hi", 256'(o_start), 256'(1'b1));
        core_busy = 1;
        rd(32'h08, d);
        check("t3_start_lo", 256'(o_start), 256'(1'b0));
        check("t3_status_busy", 256'(d), 256'(32'h1));
        repeat (3) @(negedge clk);
        core_done = 1; core_busy = 0;
        core_dout = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        @(negedge clk);
        core_done = 0; core_dout = '0;
        rd(32'h08, d);
        check("t3_status_done", 256'(d), 256'(32'h2));
        check("t3_irq", 256'(o_irq), 256'(1'b1));
        for (int i = 0; i < 4; i++) begin
            rd(32'(32'h80 + 4*i), d);
            check($sformatf("t3_dout%0d", i), 256'(d), 256'({4{8'(8'h11 * (i + 1))}}));
        end
        wr_beat(32'h0C, 32'h2, 4'hF);
        rd(32'h08, d);
        check("t3_status_clr", 256'(d), 256'(32'h0));
        check("t3_irq_clr", 256'(o_irq), 256'(1'b0));

        core_busy = 1;
        wr_beat(32'h40, 32'h1234, 4'hF);
        wr_beat(32'h00, 32'h1, 4'hF);
        check("t4_no_start", 256'(o_start), 256'(1'b0));
        check("t4_din", 256'(o_din[31:0]), 256'd0);
        rd(32'h08, d);
        check("t4_status_err", 256'(d), 256'(32'h5));
        core_busy = 0;
        wr_beat(32'h0C, 32'h4, 4'hF);
        rd(32'h08, d);
        check("t4_err_clr", 256'(d), 256'(32'h0));

        @(negedge clk);
        core_done = 1; core_dout = {4{32'hA5A5A5A5}};
        bus.wr_en = 1; bus.wr_addr = 32'h0C; bus.wr_data = 32'h2; bus.wr_strb = 4'hF;
        $display("[TB] wr 0000000c <= 00000002 strb 1111 with core_done");
        @(negedge clk);
        core_done = 0; bus.wr_en = 0;
        rd(32'h08, d);
        check("t5_done_wins", 256'(d), 256'(32'h2));

        wr_beat(32'h04, 32'h2, 4'hF);
        wr_beat(32'h00, 32'h6, 4'hF);
        wr_beat(32'h10, 32'hCAFEF00D, 4'hF);
        rd(32'h10, d);
        check("t6_key0", 256'(d), 256'(32'hCAFEF00D));
        @(negedge clk);
        bus.wr_en = 1; bus.wr_addr = 32'h00; bus.wr_data = 32'h1; bus.wr_strb = 4'hF;
        resetn = 0;
        $display("[TB] wr 00000000 <= 00000001 strb 1111 under reset");
        @(negedge clk);
        bus.wr_en = 0;
        check("t6_start", 256'(o_start), 256'(1'b0));
        check("t6_zero", {o_key, 120'd0, o_mode, o_decrypt, o_irq, bus.rd_valid, bus.rd_data[2:0]},
              256'd0);
        check("t6_zero_blk", {o_din, o_iv}, 256'd0);
        @(negedge clk);
        resetn = 1;

        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            resetn = ($urandom_range(0, 149) != 0);
            ra = $urandom();
            ra[7:0] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 35) * 4);
            if ($urandom_range(0, 9) == 0) ra[7:0] = 8'($urandom());
            bus.wr_en = 1'($urandom_range(0, 1));
            bus.wr_addr = ra;
            bus.wr_data = $urandom();
            bus.wr_strb = 4'($urandom());
            ra = $urandom();
            ra[7:0] = 8'($urandom_range(0, 36) * 4);
            bus.rd_en = 1'($urandom_range(0, 1));
            bus.rd_addr = ra;
            if ($urandom_range(0, 7) == 0) core_busy = ~core_busy;
            core_done = ($urandom_range(0, 9) == 0);
            core_dout = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (bus.wr_en)
                $display("[TB] wr %08h <= %08h strb %b", bus.wr_addr, bus.wr_data, bus.wr_strb);
            if (bus.rd_en)
                $display("[TB] rd %08h", bus.rd_addr);
        end
        @(negedge clk);
        bus.wr_en = 0; bus.rd_en = 0; core_done = 0; core_busy = 0; resetn = 1;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
